// File: rtl/sine_note_sequencer_pkg.sv
// Shared definitions for the sine note sequencer.
// Holds the default widths, the C4 and rest step divisors, the FSM state
// encoding, the note table entry layout, and small helpers that map the
// "0 means something else" encodings of div and dur onto real counts.
package sine_note_sequencer_pkg;

  localparam int ADDR_W    = 8;          // sine BRAM address width
  localparam int DIV_W     = 16;         // clocks per address step
  localparam int DUR_W     = 24;         // address steps per note
  localparam int IDX_W     = 3;          // note table index width
  localparam int NUM_NOTES = 2 ** IDX_W;
  localparam int LEN_W     = IDX_W + 1;  // seq_len must be able to hold NUM_NOTES
  localparam int BRAM_LAT  = 2;          // BRAM read latency in clocks

  // C4 at 100 MHz: 100e6 / (261.63 Hz * 256 steps) ~= 1493 clocks per step.
  localparam logic [DIV_W-1:0] NOTE_C4_DIV = DIV_W'(1493);
  // A rest keeps the C4 step rate so its duration is measured in the same steps.
  localparam logic [DIV_W-1:0] REST_DIV    = NOTE_C4_DIV;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [DIV_W-1:0] div;  // 0 = rest
    logic [DUR_W-1:0] dur;  // 0 behaves as 1
  } note_t;

  // Divisor actually used for step timing.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? REST_DIV : d;
  endfunction

  // Duration actually used; a zero duration still plays one step.
  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

endpackage

// File: rtl/sine_note_sequencer_if.sv
// Bundle of control, configuration and BRAM/PWM-side signals of the
// sine note sequencer.
//   master : CPU/config side (drives start/stop/cfg, observes status)
//   slave  : the sequencer itself
// Signalling: there is no valid/ready pair here. start, stop and cfg_we are
// single-cycle strobes sampled on the rising clock edge; seq_len and loop_en
// are sampled together with an accepted start; cfg_idx/div/dur are sampled
// together with cfg_we. done, cfg_err and sample_valid are single-cycle pulses.
// state is the live FSM state, exported for observation only.
interface sine_note_sequencer_if;
  import sine_note_sequencer_pkg::*;

  logic              start;
  logic              stop;
  logic              loop_en;
  logic [LEN_W-1:0]  seq_len;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [DIV_W-1:0]  cfg_div;
  logic [DUR_W-1:0]  cfg_dur;

  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic              sample_valid;
  logic              mute;
  logic              busy;
  logic [IDX_W-1:0]  note_idx;
  logic              done;
  logic              cfg_err;
  seq_state_t        state;

  modport master (
    output start, stop, loop_en, seq_len, cfg_we, cfg_idx, cfg_div, cfg_dur,
    input  bram_addr, bram_en, sample_valid, mute, busy, note_idx, done,
           cfg_err, state
  );

  modport slave (
    input  start, stop, loop_en, seq_len, cfg_we, cfg_idx, cfg_div, cfg_dur,
    output bram_addr, bram_en, sample_valid, mute, busy, note_idx, done,
           cfg_err, state
  );

endinterface

// File: rtl/sine_note_sequencer_note_table.sv
// note_table: NUM_NOTES-entry register file of {div, dur} note entries.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   we         : write strobe, entry updated on the next rising edge
//   wr_idx     : entry to write
//   wr_note    : data to write
//   rd_idx     : entry to read (asynchronous read)
//   rd_note    : contents of entry rd_idx
module note_table
  import sine_note_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  note_t            wr_note,
  input  logic [IDX_W-1:0] rd_idx,
  output note_t            rd_note
);

  note_t mem_q [NUM_NOTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wr_idx] <= wr_note;
    end
  end

  assign rd_note = mem_q[rd_idx];

endmodule

// File: rtl/sine_note_sequencer.sv
// sine_note_sequencer: steps the sine BRAM address at each note's divisor
// rate, walks a programmable note table, and tells the PWM stage when the
// BRAM output is a fresh sample and when to stay silent.
// Ports:
//   clk    : system clock (100 MHz)
//   rst_n  : asynchronous active-low reset
//   sif    : slave side of sine_note_sequencer_if (control, config, BRAM
//            address/enable, sample_valid, mute, status pulses, FSM state)
module sine_note_sequencer
  import sine_note_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  sine_note_sequencer_if.slave sif
);

  seq_state_t          state_q, state_d;
  logic [IDX_W-1:0]    note_idx_q, note_idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    step_cnt_q, step_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                loop_q, loop_d;
  logic                step_q, step_d;
  logic [BRAM_LAT-1:0] sv_sr_q, sv_sr_d;
  logic                en_q, en_d;
  logic                mute_q, mute_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic  tbl_we;
  note_t wr_note;
  note_t rd_note;
  logic  step_hit;
  logic  note_end;
  logic  last_note;
  logic  seq_len_ok;

  assign wr_note.div = sif.cfg_div;
  assign wr_note.dur = sif.cfg_dur;

  // The read port follows the next note index so the entry being loaded is
  // visible one cycle early; this lets bram_en/mute be registered and still
  // be correct during the LOAD cycle itself.
  note_table u_note_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (tbl_we),
    .wr_idx  (sif.cfg_idx),
    .wr_note (wr_note),
    .rd_idx  (note_idx_d),
    .rd_note (rd_note)
  );

  assign step_hit   = (div_cnt_q == eff_div(div_q) - DIV_W'(1));
  assign note_end   = (step_cnt_q == eff_dur(dur_q) - DUR_W'(1));
  assign last_note  = ({1'b0, note_idx_q} == len_q - LEN_W'(1));
  assign seq_len_ok = (sif.seq_len != '0) && (sif.seq_len <= LEN_W'(NUM_NOTES));

  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    addr_d     = addr_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    dur_d      = dur_q;
    step_cnt_d = step_cnt_q;
    len_d      = len_q;
    loop_d     = loop_q;
    step_d     = 1'b0;
    sv_sr_d    = {sv_sr_q[BRAM_LAT-2:0], step_q};
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    tbl_we     = 1'b0;
    en_d       = 1'b0;

    // The table may only change while nothing is reading it.
    if (sif.cfg_we) begin
      if (state_q == ST_IDLE) tbl_we = 1'b1;
      else                    cfg_err_d = 1'b1;
    end

    if (sif.stop) begin
      // Abort wins over everything, including a simultaneous start; samples
      // still in the BRAM pipeline must not be announced.
      state_d = ST_IDLE;
      sv_sr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sif.start) begin
            if (seq_len_ok) begin
              state_d    = ST_LOAD;
              note_idx_d = '0;
              addr_d     = '0;
              len_d      = sif.seq_len;
              loop_d     = sif.loop_en;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          div_d      = rd_note.div;
          dur_d      = rd_note.dur;
          div_cnt_d  = '0;
          step_cnt_d = '0;
          state_d    = ST_PLAY;
        end
        ST_PLAY: begin
          if (step_hit) begin
            div_cnt_d  = '0;
            step_cnt_d = step_cnt_q + DUR_W'(1);
            // A rest keeps time but holds the phase and emits no sample.
            if (div_q != '0) begin
              addr_d = addr_q + ADDR_W'(1);
              step_d = 1'b1;
            end
            if (note_end) begin
              if (!last_note) begin
                note_idx_d = note_idx_q + IDX_W'(1);
                state_d    = ST_LOAD;
              end else if (loop_q) begin
                note_idx_d = '0;
                state_d    = ST_LOAD;
              end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Audible only while a non-rest note is loading or playing.
    case (state_d)
      ST_LOAD: en_d = (rd_note.div != '0);
      ST_PLAY: en_d = (div_d != '0);
      default: en_d = 1'b0;
    endcase
    mute_d = ~en_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      note_idx_q <= '0;
      addr_q     <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      dur_q      <= '0;
      step_cnt_q <= '0;
      len_q      <= '0;
      loop_q     <= 1'b0;
      step_q     <= 1'b0;
      sv_sr_q    <= '0;
      en_q       <= 1'b0;
      mute_q     <= 1'b1;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      addr_q     <= addr_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      dur_q      <= dur_d;
      step_cnt_q <= step_cnt_d;
      len_q      <= len_d;
      loop_q     <= loop_d;
      step_q     <= step_d;
      sv_sr_q    <= sv_sr_d;
      en_q       <= en_d;
      mute_q     <= mute_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign sif.bram_addr    = addr_q;
  assign sif.bram_en      = en_q;
  assign sif.sample_valid = sv_sr_q[BRAM_LAT-1];
  assign sif.mute         = mute_q;
  assign sif.busy         = (state_q != ST_IDLE);
  assign sif.note_idx     = note_idx_q;
  assign sif.done         = done_q;
  assign sif.cfg_err      = cfg_err_q;
  assign sif.state        = state_q;

endmodule

// File: tb/tb_sine_note_sequencer.sv
// Bench for sine_note_sequencer. A note-level model turns the note table,
// seq_len and loop_en into a timeline of events (address steps, fresh
// samples, note changes, done, cfg errors) plus busy/enable cycle totals;
// the observed run is reduced to the same form and compared.
module tb_sine_note_sequencer;
  import sine_note_sequencer_pkg::*;

  localparam int K_ADDR = 1;
  localparam int K_SV   = 2;
  localparam int K_IDX  = 3;
  localparam int K_DONE = 4;
  localparam int K_ERR  = 5;
  localparam int C4     = 1493;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sine_note_sequencer_if sif ();

  sine_note_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.slave)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  // model state: table contents and the sequencer's held address / index
  int m_div [NUM_NOTES];
  int m_dur [NUM_NOTES];
  int m_addr = 0;
  int m_idx  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input int kind, input int rel, input int val);
    return {4'(kind), 16'(rel), 12'(val)};
  endfunction

  // Note-level reference: note k occupies [t, t + 1 + d*n) (one LOAD cycle,
  // then n steps of d clocks). Times are clocks after the accepted start edge.
  task automatic model_run(input int len, input bit lp, input int win_in,
                           output int win, output int busy_exp, output int en_exp);
    int t, idx, d, n, ts, seg_end;
    bit fin;
    exp_q.delete();
    if (m_addr != 0) exp_q.push_back(ev(K_ADDR, 0, 0));
    if (m_idx != 0)  exp_q.push_back(ev(K_IDX, 0, 0));
    m_addr = 0; m_idx = 0;
    t = 0; idx = 0; fin = 0; en_exp = 0; win = win_in;
    while (!fin) begin
      d = (m_div[idx] == 0) ? C4 : m_div[idx];
      n = (m_dur[idx] == 0) ? 1 : m_dur[idx];
      seg_end = t + 1 + d * n;
      if (m_div[idx] != 0) en_exp += ((lp && seg_end > win) ? win : seg_end) - t;
      for (int j = 1; j <= n; j++) begin
        ts = t + 1 + d * j;
        if (lp && ts >= win) break;
        if (m_div[idx] != 0) begin
          m_addr = (m_addr + 1) % 256;
          exp_q.push_back(ev(K_ADDR, ts, m_addr));
          if (!lp || ts + 2 < win) exp_q.push_back(ev(K_SV, ts + 2, 1));
        end
      end
      if (lp && seg_end >= win) break;
      t = seg_end;
      if (idx < len - 1)  idx++;
      else if (lp)        idx = 0;
      else begin
        exp_q.push_back(ev(K_DONE, t, 1));
        fin = 1;
      end
      if (!fin && idx != m_idx) exp_q.push_back(ev(K_IDX, t, idx));
      m_idx = idx;
    end
    if (!lp) begin
      win = t + 3;
      busy_exp = t;
    end else begin
      busy_exp = win;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_note(input int idx, input int div, input int dur);
    @(negedge clk);
    sif.cfg_we  = 1'b1;
    sif.cfg_idx = IDX_W'(idx);
    sif.cfg_div = DIV_W'(div);
    sif.cfg_dur = DUR_W'(dur);
    @(negedge clk);
    sif.cfg_we = 1'b0;
    check("wr_no_err", 32'(sif.cfg_err), 0);
    m_div[idx] = div;
    m_dur[idx] = dur;
  endtask

  task automatic bad_start(input int len);
    @(negedge clk);
    sif.seq_len = LEN_W'(len);
    sif.start   = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    check("bad_start_err", 32'(sif.cfg_err), 1);
    check("bad_start_busy", 32'(sif.busy), 0);
    @(negedge clk);
    check("bad_start_err_clr", 32'(sif.cfg_err), 0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_addr"},  32'(sif.bram_addr), 0);
    check({pfx, "_en"},    32'(sif.bram_en), 0);
    check({pfx, "_sv"},    32'(sif.sample_valid), 0);
    check({pfx, "_mute"},  32'(sif.mute), 1);
    check({pfx, "_busy"},  32'(sif.busy), 0);
    check({pfx, "_idx"},   32'(sif.note_idx), 0);
    check({pfx, "_done"},  32'(sif.done), 0);
    check({pfx, "_err"},   32'(sif.cfg_err), 0);
  endtask

  // Play the table. Looping runs are cut by stop after win_in cycles
  // (optionally with start in the same cycle); poke_rel >= 0 attempts a
  // table write at that cycle, which must be refused.
  task automatic play(input int len, input bit lp, input int win_in,
                      input bit stop_with_start, input int poke_rel);
    int win, busy_exp, en_exp, busy_n, en_n, mute_bad, quiet;
    logic [ADDR_W-1:0] prev_addr;
    logic [IDX_W-1:0]  prev_idx;
    model_run(len, lp, win_in, win, busy_exp, en_exp);
    if (poke_rel >= 0) exp_q.push_back(ev(K_ERR, poke_rel + 1, 1));
    obs_q.delete();
    busy_n = 0; en_n = 0; mute_bad = 0;
    @(negedge clk);
    prev_addr   = sif.bram_addr;
    prev_idx    = sif.note_idx;
    sif.seq_len = LEN_W'(len);
    sif.loop_en = lp;
    sif.start   = 1'b1;
    for (int rel = 0; rel < win; rel++) begin
      @(negedge clk);
      sif.start  = 1'b0;
      sif.cfg_we = 1'b0;
      if (sif.bram_addr != prev_addr) obs_q.push_back(ev(K_ADDR, rel, int'(sif.bram_addr)));
      if (sif.note_idx != prev_idx)   obs_q.push_back(ev(K_IDX, rel, int'(sif.note_idx)));
      if (sif.sample_valid)           obs_q.push_back(ev(K_SV, rel, 1));
      if (sif.done)                   obs_q.push_back(ev(K_DONE, rel, 1));
      if (sif.cfg_err)                obs_q.push_back(ev(K_ERR, rel, 1));
      prev_addr = sif.bram_addr;
      prev_idx  = sif.note_idx;
      busy_n += int'(sif.busy);
      en_n   += int'(sif.bram_en);
      if (sif.mute == sif.bram_en) mute_bad++;
      if (rel == poke_rel) begin
        sif.cfg_we  = 1'b1;
        sif.cfg_idx = '0;
        sif.cfg_div = DIV_W'(16'h1234);
        sif.cfg_dur = DUR_W'(77);
      end
      if (lp && rel == win - 1) begin
        sif.stop  = 1'b1;
        sif.start = stop_with_start;
      end
    end
    if (lp) begin
      quiet = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        sif.stop  = 1'b0;
        sif.start = 1'b0;
        if (k == 0) check("stop_busy", 32'(sif.busy), 0);
        quiet += int'(sif.sample_valid) + int'(sif.done) + int'(sif.cfg_err) + int'(sif.bram_en);
      end
      check("stop_quiet", quiet, 0);
    end
    exp_q.sort();
    obs_q.sort();
    check("event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check("event", obs_q[i], exp_q[i]);
    end
    check("busy_cycles", busy_n, busy_exp);
    check("en_cycles", en_n, en_exp);
    check("mute_vs_en", mute_bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, busy_n;
    bit lp;
    sif.start = 1'b0; sif.stop = 1'b0; sif.loop_en = 1'b0; sif.seq_len = '0;
    sif.cfg_we = 1'b0; sif.cfg_idx = '0; sif.cfg_div = '0; sif.cfg_dur = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      m_div[i] = 0;
      m_dur[i] = 0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");

    // single note: steps every 3 clocks, done on the second step
    write_note(0, 3, 2);
    play(1, 1'b0, 0, 1'b0, -1);

    // two notes, phase continues across the boundary, loop wraps to entry 0
    write_note(0, 4, 1);
    write_note(1, 2, 3);
    play(2, 1'b1, 40, 1'b0, -1);

    // rest: silent, no samples, done after two C4-rate steps
    write_note(0, 0, 2);
    play(1, 1'b0, 0, 1'b0, -1);

    // rejected starts
    bad_start(0);
    bad_start(9);

    // stop together with start while playing
    write_note(0, 7, 20);
    play(1, 1'b1, 50, 1'b1, -1);

    // table write while playing is refused; replay shows the entry is intact
    write_note(0, 5, 6);
    play(1, 1'b1, 30, 1'b0, 10);
    play(1, 1'b0, 0, 1'b0, -1);

    // address wraps 255 -> 0
    write_note(0, 1, 300);
    play(1, 1'b0, 0, 1'b0, -1);

    // randomized melodies
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        if ($urandom_range(0, 7) == 0) write_note(i, 0, $urandom_range(0, 1));
        else write_note(i, $urandom_range(1, 6), $urandom_range(0, 4));
      end
      len = $urandom_range(1, NUM_NOTES);
      lp  = 1'($urandom_range(0, 1));
      play(len, lp, 200, 1'($urandom_range(0, 1)), -1);
    end

    // asynchronous reset in the middle of playback
    write_note(0, 5, 50);
    @(negedge clk);
    sif.seq_len = LEN_W'(1);
    sif.loop_en = 1'b1;
    sif.start   = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (30) @(negedge clk);
    check("pre_reset_busy", 32'(sif.busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    busy_n = 0;
    repeat (10) begin
      @(negedge clk);
      busy_n += int'(sif.busy) + int'(sif.bram_en);
    end
    check("no_resume", busy_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
